// File: rtl/seq_mul_div.sv
// Iterative MUL / DIVU / REMU unit feeding the reg_file write port.
// Shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module seq_mul_div #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  input  logic [ADDR_W-1:0] dest_reg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] write_reg,
  output logic [WIDTH-1:0]  write_data,
  output logic              RegWrite
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIVU = 2'b01, OP_REMU = 2'b10} op_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d, op_dec;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   dest_q, dest_d, wreg_q, wreg_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH-1:0]    mul_acc;
  logic [WIDTH:0]      rem_shift;
  logic                rem_ge;
  logic [WIDTH:0]      rem_sub;

  always_comb begin
    unique case (op)
      2'b01:   op_dec = OP_DIVU;
      2'b10:   op_dec = OP_REMU;
      default: op_dec = OP_MUL;
    endcase
  end

  // a_q doubles as multiplicand (shifting left) and dividend/quotient shift register;
  // acc_q is the product accumulator or the partial remainder.
  always_comb begin
    mul_acc   = acc_q + (b_q[0] ? a_q : '0);
    rem_shift = {acc_q, a_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, b_q};
    rem_sub   = rem_shift - {1'b0, b_q};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op_dec;
          a_d    = operand_a;
          b_d    = operand_b;
          acc_d  = '0;
          cnt_d  = '0;
          dest_d = dest_reg;
          if (op_dec != OP_MUL && operand_b == '0) begin
            state_d = DONE;
            wreg_d  = dest_reg;
            wdata_d = (op_dec == OP_REMU) ? operand_a : '1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], rem_ge};
        end
        if (cnt_d == CW'(WIDTH)) begin
          state_d = DONE;
          wreg_d  = dest_q;
          wdata_d = (op_q == OP_DIVU) ? a_d : acc_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign RegWrite   = done;
  assign write_reg  = wreg_q;
  assign write_data = wdata_q;

endmodule
